// File: rtl/can_host_bus_if.sv
// can_host_bus_if: synchronizes an async 8051-style host bus and drives register bank strobes
module can_host_bus_if #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ale_i,
   input  logic                  cs_n_i,
   input  logic                  rd_n_i,
   input  logic                  wr_n_i,
   input  logic [DATA_WIDTH-1:0] ad_i,
   output logic [DATA_WIDTH-1:0] ad_o,
   output logic                  ad_oe,
   output logic [DATA_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   output logic                  reg_we,
   output logic                  reg_re,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  bus_err
);
   typedef enum logic [1:0] {BLOCK, IDLE, WRITE, READ} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] ale_s, cs_s, rd_s, wr_s;
   logic [DATA_WIDTH-1:0] ad_s [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] ad;
   logic ale, cs_n, rd_n, wr_n, ale_q, rd_q, wr_q, armed;
   logic ale_fall, rd_fall, rd_rise, wr_fall, wr_rise, quiet;
   logic we_nx, re_nx, oe_nx, err_nx;

   assign ale_fall = ale_q & ~ale;
   assign rd_fall  = rd_q & ~rd_n;
   assign rd_rise  = ~rd_q & rd_n;
   assign wr_fall  = wr_q & ~wr_n;
   assign wr_rise  = ~wr_q & wr_n;
   // both strobes idle through the whole chain, so no edge is still in flight
   assign quiet    = armed & (&rd_s) & rd_n & rd_q & (&wr_s) & wr_n & wr_q;

   // synchronizer chains, one aligning stage shared by data and controls, and edge history
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ale_s <= '0;
         cs_s  <= '1;
         rd_s  <= '1;
         wr_s  <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) ad_s[i] <= '0;
         ale   <= 1'b0;
         cs_n  <= 1'b1;
         rd_n  <= 1'b1;
         wr_n  <= 1'b1;
         ad    <= '0;
         ale_q <= 1'b0;
         rd_q  <= 1'b1;
         wr_q  <= 1'b1;
         armed <= 1'b0;
      end else begin
         ale_s <= {ale_s[SYNC_STAGES-2:0], ale_i};
         cs_s  <= {cs_s[SYNC_STAGES-2:0], cs_n_i};
         rd_s  <= {rd_s[SYNC_STAGES-2:0], rd_n_i};
         wr_s  <= {wr_s[SYNC_STAGES-2:0], wr_n_i};
         ad_s[0] <= ad_i;
         for (int i = 1; i < SYNC_STAGES; i++) ad_s[i] <= ad_s[i-1];
         ale   <= ale_s[SYNC_STAGES-1];
         cs_n  <= cs_s[SYNC_STAGES-1];
         rd_n  <= rd_s[SYNC_STAGES-1];
         wr_n  <= wr_s[SYNC_STAGES-1];
         ad    <= ad_s[SYNC_STAGES-1];
         ale_q <= ale;
         rd_q  <= rd_n;
         wr_q  <= wr_n;
         armed <= 1'b1;
      end

   // access state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= BLOCK;
      else     state <= state_nx;

   // next state and next output decisions
   always_comb begin
      state_nx = state;
      we_nx    = 1'b0;
      re_nx    = 1'b0;
      oe_nx    = ad_oe;
      err_nx   = 1'b0;
      case (state)
         BLOCK: if (quiet) state_nx = IDLE;
         IDLE:
            if (rd_fall && wr_fall) begin
               state_nx = BLOCK;
               err_nx   = 1'b1;
            end else if (wr_fall && !cs_n && rd_n) begin
               state_nx = WRITE;
            end else if (rd_fall && !cs_n && wr_n) begin
               state_nx = READ;
               re_nx    = 1'b1;
               oe_nx    = 1'b1;
            end
         WRITE:
            if (rd_fall) begin
               state_nx = BLOCK;
               err_nx   = 1'b1;
            end else if (wr_rise) begin
               state_nx = IDLE;
               we_nx    = ~cs_n;
               err_nx   = cs_n;
            end
         READ:
            if (wr_fall) begin
               state_nx = BLOCK;
               err_nx   = 1'b1;
               oe_nx    = 1'b0;
            end else if (rd_rise) begin
               state_nx = IDLE;
               oe_nx    = 1'b0;
            end
         default: state_nx = BLOCK;
      endcase
   end

   // registered outputs; read data is captured once, on the read strobe decision
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ad_o      <= '0;
         ad_oe     <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         reg_we  <= we_nx;
         reg_re  <= re_nx;
         ad_oe   <= oe_nx;
         bus_err <= bus_err | err_nx;
         if (re_nx) ad_o <= reg_rdata;
         if (we_nx) reg_wdata <= ad;
         if (ale_fall) reg_addr <= ad;
      end
endmodule
